// File: rtl/cnn_dot_seq_pkg.sv
// Shared definitions for the sequential dot-product engine.
// Holds the controller state encoding, the default length/accumulator
// widths, and the fixed operand widths of the 8x14 signed multiply.
package cnn_dot_seq_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int ACC_W_DEF = 32;

  // activation, weight and full-precision product widths
  localparam int A_W = 8;
  localparam int W_W = 14;
  localparam int P_W = 22;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/cnn_dot_seq_mul.sv
// Purely combinational signed 8x14 -> 22 multiplier.  Kept as its own
// module so it maps onto a single DSP slice.
// Ports:
//   a : signed activation operand (A_W bits)
//   w : signed weight operand (W_W bits)
//   p : signed full-precision product (P_W bits)
module cnn_dot_seq_mul
  import cnn_dot_seq_pkg::*;
(
  input  logic signed [A_W-1:0] a,
  input  logic signed [W_W-1:0] w,
  output logic signed [P_W-1:0] p
);

  logic signed [P_W-1:0] a_x;
  logic signed [P_W-1:0] w_x;

  // sign-extend both operands to the product width before multiplying
  assign a_x = P_W'(a);
  assign w_x = P_W'(w);
  assign p   = a_x * w_x;

endmodule

// File: rtl/cnn_dot_seq.sv
// Sequential signed dot product of two vectors held in external
// single-port memories with one-cycle read latency.  One element pair is
// issued per cycle; products pass through a registered multiply stage and
// then into the accumulator, so two drain cycles follow the last issue.
// Ports:
//   ap_clk, ap_rst          : clock, async active-high reset
//   ap_start                : start request, sampled in IDLE only
//   ap_done, ap_ready       : one-cycle pulse when ap_return is valid
//   ap_idle                 : high in IDLE
//   len                     : element count, latched at start
//   a_address0/a_ce0/a_q0   : activation memory port (8-bit signed data)
//   w_address0/w_ce0/w_q0   : weight memory port (14-bit signed data)
//   ap_return               : signed result, held until the next DONE
//
// state  | meaning
// IDLE   | waiting for ap_start
// RUN    | issuing one address pair per cycle
// DRAIN1 | last read data reaches the multiplier register
// DRAIN2 | last product reaches the accumulator
// DONE   | result valid, done/ready pulse
module cnn_dot_seq
  import cnn_dot_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [LEN_W-1:0]        len,
  output logic [LEN_W-1:0]        a_address0,
  output logic                    a_ce0,
  input  logic signed [A_W-1:0]   a_q0,
  output logic [LEN_W-1:0]        w_address0,
  output logic                    w_ce0,
  input  logic signed [W_W-1:0]   w_q0,
  output logic signed [ACC_W-1:0] ap_return
);

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic                    ce;
  logic                    rd_v_q;
  logic                    prod_v_q;
  logic signed [P_W-1:0]   prod_q;
  logic signed [P_W-1:0]   mul_p;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] ret_q;
  logic                    start_ok;

  assign start_ok = (state_q == S_IDLE) && ap_start;

  cnn_dot_seq_mul u_mul (
    .a (a_q0),
    .w (w_q0),
    .p (mul_p)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ap_idle = 1'b0;
    ap_done = 1'b0;
    ce      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        ce = 1'b1;
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN1;
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_DONE;
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ap_ready   = ap_done;
  assign a_ce0      = ce;
  assign w_ce0      = ce;
  assign a_address0 = cnt_q;
  assign w_address0 = cnt_q;
  assign ap_return  = ret_q;

  always_comb begin
    acc_d = acc_q;
    if (start_ok) begin
      acc_d = '0;
    end else if (prod_v_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      len_q    <= '0;
      cnt_q    <= '0;
      rd_v_q   <= 1'b0;
      prod_v_q <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      ret_q    <= '0;
    end else begin
      if (start_ok) begin
        len_q <= len;
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      // rd_v_q marks the cycle in which memory data from an issue is valid
      rd_v_q   <= ce;
      prod_v_q <= rd_v_q;
      if (rd_v_q) begin
        prod_q <= mul_p;
      end
      acc_q <= acc_d;
      // load the result on entry to DONE so it is valid during the pulse;
      // acc_d already includes the final product folded in on this edge
      if (state_d == S_DONE) begin
        ret_q <= acc_d;
      end
    end
  end

endmodule
